// File: rtl/video_timing_fb_swap.sv
// Raster timing generator with frame-synchronous front-buffer swap.
// The swap handshake is 4-phase; a new base address only takes effect on a frame boundary.
module video_timing_fb_swap #(
    parameter int          H_TOTAL     = 800,
    parameter int          V_TOTAL     = 256,
    parameter int          H_BPORCH    = 40,
    parameter int          H_ACTIVE    = 320,
    parameter int          V_BPORCH    = 16,
    parameter int          V_ACTIVE    = 240,
    parameter int          HS_WIDTH    = 1,
    parameter int          VS_X_OFFSET = 3,
    parameter logic [21:0] RESET_BASE  = 22'h000000
) (
    input  logic        clk_video,
    input  logic        reset_n,
    output logic [9:0]  x_count,
    output logic [9:0]  y_count,
    output logic        line_start,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic        de,
    input  logic        swap_req,
    input  logic [21:0] back_addr,
    output logic        swap_ack,
    output logic [21:0] fb_base_addr,
    output logic [15:0] frame_count
);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FIRST = 10'(H_BPORCH);
    localparam logic [9:0] H_END   = 10'(H_BPORCH + H_ACTIVE);
    localparam logic [9:0] V_FIRST = 10'(V_BPORCH);
    localparam logic [9:0] V_END   = 10'(V_BPORCH + V_ACTIVE);
    localparam logic [9:0] HS_END  = 10'(HS_WIDTH);
    localparam logic [9:0] VS_X    = 10'(VS_X_OFFSET);

    typedef enum logic [1:0] {IDLE, PENDING, ACK} swap_state_t;

    swap_state_t state_reg;
    logic [21:0] pending_addr_reg;
    logic        req_meta_reg;
    logic        req_s;
    logic        started_reg;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        frame_end;

    // The first edge after reset presents (0,0) with its strobes, so the
    // counters only start advancing once that position has been shown.
    always_comb begin
        x_next = '0;
        y_next = '0;
        if (started_reg) begin
            if (x_count == H_LAST) begin
                x_next = '0;
                y_next = (y_count == V_LAST) ? 10'd0 : y_count + 10'd1;
            end else begin
                x_next = x_count + 10'd1;
                y_next = y_count;
            end
        end
    end

    assign frame_end = started_reg && (x_count == H_LAST) && (y_count == V_LAST);

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            started_reg <= 1'b0;
            x_count     <= '0;
            y_count     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            de          <= 1'b0;
            frame_count <= '0;
        end else begin
            started_reg <= 1'b1;
            x_count     <= x_next;
            y_count     <= y_next;
            line_start  <= (x_next == 10'd0);
            frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
            hs          <= (x_next < HS_END);
            vs          <= (y_next == 10'd0) && (x_next == VS_X);
            de          <= (x_next >= H_FIRST) && (x_next < H_END) &&
                           (y_next >= V_FIRST) && (y_next < V_END);
            if ((x_next == 10'd0) && (y_next == 10'd0))
                frame_count <= frame_count + 16'd1;
        end
    end

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            req_meta_reg <= 1'b0;
            req_s        <= 1'b0;
        end else begin
            req_meta_reg <= swap_req;
            req_s        <= req_meta_reg;
        end
    end

    // A request landing exactly on the frame-end cycle is only captured here,
    // so it is applied one frame later rather than bypassed.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            pending_addr_reg <= '0;
            swap_ack         <= 1'b0;
            fb_base_addr     <= RESET_BASE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_s && !swap_ack) begin
                        pending_addr_reg <= back_addr;
                        state_reg        <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_end) begin
                        fb_base_addr <= pending_addr_reg;
                        swap_ack     <= 1'b1;
                        state_reg    <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        swap_ack  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_timing_fb_swap.sv
// Bench for video_timing_fb_swap on a shrunken raster: a position model derived
// from the edge count is checked every cycle, plus directed swap scenarios.
module tb_video_timing_fb_swap;
    localparam int H   = 20;
    localparam int V   = 12;
    localparam int HBP = 4;
    localparam int HAC = 10;
    localparam int VBP = 2;
    localparam int VAC = 9;
    localparam int HSW = 2;
    localparam int VSX = 3;
    localparam int FR  = H * V;
    localparam logic [21:0] RB = 22'h3F0000;

    logic        clk_video = 1'b0;
    logic        reset_n;
    logic [9:0]  x_count, y_count;
    logic        line_start, frame_start, hs, vs, de;
    logic        swap_req;
    logic [21:0] back_addr;
    logic        swap_ack;
    logic [21:0] fb_base_addr;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Model state: edges since reset release, sync history, handshake phase.
    int          m_cycles;
    logic        m_s1, m_s2;
    int          m_phase;
    logic [21:0] m_pend, m_base;
    logic        m_ack;

    video_timing_fb_swap #(
        .H_TOTAL(H), .V_TOTAL(V), .H_BPORCH(HBP), .H_ACTIVE(HAC),
        .V_BPORCH(VBP), .V_ACTIVE(VAC), .HS_WIDTH(HSW), .VS_X_OFFSET(VSX),
        .RESET_BASE(RB)
    ) dut (
        .clk_video(clk_video), .reset_n(reset_n),
        .x_count(x_count), .y_count(y_count),
        .line_start(line_start), .frame_start(frame_start),
        .hs(hs), .vs(vs), .de(de),
        .swap_req(swap_req), .back_addr(back_addr),
        .swap_ack(swap_ack), .fb_base_addr(fb_base_addr),
        .frame_count(frame_count)
    );

    always #5 clk_video = ~clk_video;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            m_cycles <= 0;
            m_s1     <= 1'b0;
            m_s2     <= 1'b0;
            m_phase  <= 0;
            m_pend   <= '0;
            m_ack    <= 1'b0;
            m_base   <= RB;
        end else begin
            case (m_phase)
                0: if (m_s2) begin
                    m_pend  <= back_addr;
                    m_phase <= 1;
                end
                1: if (m_cycles > 0 && ((m_cycles - 1) % FR) == FR - 1) begin
                    m_base  <= m_pend;
                    m_ack   <= 1'b1;
                    m_phase <= 2;
                end
                default: if (!m_s2) begin
                    m_ack   <= 1'b0;
                    m_phase <= 0;
                end
            endcase
            m_cycles <= m_cycles + 1;
            m_s1     <= swap_req;
            m_s2     <= m_s1;
        end
    end

    function automatic int pos();
        return (m_cycles == 0) ? -1 : (m_cycles - 1) % FR;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_video) begin
        if (cmp_en) begin
            int p, fp, ex, ey, efc;
            bit els, efs, ehs, evs, ede;
            if (m_cycles == 0) begin
                ex = 0; ey = 0; efc = 0;
                els = 0; efs = 0; ehs = 0; evs = 0; ede = 0;
            end else begin
                p   = m_cycles - 1;
                fp  = p % FR;
                ex  = fp % H;
                ey  = fp / H;
                efc = ((p / FR) + 1) % 65536;
                els = (ex == 0);
                efs = (ex == 0) && (ey == 0);
                ehs = (ex < HSW);
                evs = (ey == 0) && (ex == VSX);
                ede = (ex >= HBP) && (ex < HBP + HAC) && (ey >= VBP) && (ey < VBP + VAC);
            end
            chk("x_count", 32'(x_count), 32'(ex));
            chk("y_count", 32'(y_count), 32'(ey));
            chk("strobes", {27'd0, line_start, frame_start, hs, vs, de},
                {27'd0, els, efs, ehs, evs, ede});
            chk("frame_count", 32'(frame_count), 32'(efc));
            chk("swap_ack", 32'(swap_ack), 32'(m_ack));
            chk("fb_base_addr", 32'(fb_base_addr), 32'(m_base));
        end
    end

    task automatic tick();
        @(negedge clk_video);
        #1;
    endtask

    task automatic wait_pos(input int xq, input int yq, input string tag);
        int n = 0;
        while (pos() != yq * H + xq && n < 2 * FR + 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(pos()), 32'(yq * H + xq));
    endtask

    task automatic wait_ack_clear(input string tag);
        swap_req = 1'b0;
        tick(); tick();
        chk({tag, "_ack_held"}, 32'(swap_ack), 32'd1);
        tick();
        chk({tag, "_ack_clear"}, 32'(swap_ack), 32'd0);
        $display("[TB] %s: swap_req dropped, swap_ack=%0d three clocks later", tag, swap_ack);
    endtask

    initial begin
        int n_ls, n_fs, n_de, n_hs, n_vs, max_x, max_y;
        reset_n   = 1'b0;
        swap_req  = 1'b0;
        back_addr = '0;
        @(negedge clk_video);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk_video);
        #1;
        chk("rst_x", 32'(x_count), 32'd0);
        chk("rst_strobes", {27'd0, line_start, frame_start, hs, vs, de}, 32'd0);
        chk("rst_base", 32'(fb_base_addr), 32'(22'h3F0000));
        chk("rst_fc", 32'(frame_count), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("first_ls", 32'(line_start), 32'd1);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_fc", 32'(frame_count), 32'd1);
        $display("[TB] reset released: x=%0d y=%0d frame_start=%0d frame_count=%0d",
                 x_count, y_count, frame_start, frame_count);

        n_ls = 0; n_fs = 0; n_de = 0; n_hs = 0; n_vs = 0; max_x = 0; max_y = 0;
        for (int i = 0; i < FR; i++) begin
            n_ls += int'(line_start); n_fs += int'(frame_start); n_de += int'(de);
            n_hs += int'(hs); n_vs += int'(vs);
            if (int'(x_count) > max_x) max_x = int'(x_count);
            if (int'(y_count) > max_y) max_y = int'(y_count);
            tick();
        end
        chk("frame_ls_count", 32'(n_ls), 32'd12);
        chk("frame_fs_count", 32'(n_fs), 32'd1);
        chk("frame_de_count", 32'(n_de), 32'd90);
        chk("frame_hs_count", 32'(n_hs), 32'd24);
        chk("frame_vs_count", 32'(n_vs), 32'd1);
        chk("max_x", 32'(max_x), 32'd19);
        chk("max_y", 32'(max_y), 32'd11);
        chk("second_fc", 32'(frame_count), 32'd2);
        $display("[TB] frame1: line_start=%0d frame_start=%0d de=%0d hs=%0d vs=%0d fc_now=%0d",
                 n_ls, n_fs, n_de, n_hs, n_vs, frame_count);

        wait_pos(0, 5, "s2_pos_req");
        back_addr = 22'h012C00;
        swap_req  = 1'b1;
        wait_pos(H - 1, V - 1, "s2_pos_end");
        chk("s2_base_before", 32'(fb_base_addr), 32'(22'h3F0000));
        tick();
        chk("s2_base_after", 32'(fb_base_addr), 32'(22'h012C00));
        chk("s2_ack", 32'(swap_ack), 32'd1);
        chk("s2_fs", 32'(frame_start), 32'd1);
        $display("[TB] swap at frame boundary: fb_base_addr=%06h swap_ack=%0d", fb_base_addr, swap_ack);
        wait_ack_clear("s2");

        wait_pos(H - 3, V - 1, "s3_pos_req");
        back_addr = 22'h0ABCDE;
        swap_req  = 1'b1;
        wait_pos(0, 0, "s3_pos_fs1");
        chk("s3_base_unchanged", 32'(fb_base_addr), 32'(22'h012C00));
        chk("s3_ack_low", 32'(swap_ack), 32'd0);
        tick();
        wait_pos(0, 0, "s3_pos_fs2");
        chk("s3_base_late", 32'(fb_base_addr), 32'(22'h0ABCDE));
        chk("s3_ack", 32'(swap_ack), 32'd1);
        $display("[TB] frame-end request: applied one frame later, fb_base_addr=%06h", fb_base_addr);
        wait_ack_clear("s3");

        wait_pos(0, 3, "s4_pos_req");
        back_addr = 22'h155555;
        swap_req  = 1'b1;
        repeat (5) tick();
        reset_n  = 1'b0;
        swap_req = 1'b0;
        #1;
        chk("s4_rst_base", 32'(fb_base_addr), 32'(22'h3F0000));
        chk("s4_rst_ack", 32'(swap_ack), 32'd0);
        chk("s4_rst_xy", {12'd0, x_count, y_count}, 32'd0);
        $display("[TB] reset during PENDING: fb_base_addr=%06h swap_ack=%0d", fb_base_addr, swap_ack);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("s4_fs_after_rst", 32'(frame_start), 32'd1);
        back_addr = 22'h2AAAAA;
        swap_req  = 1'b1;
        wait_pos(H - 1, V - 1, "s4_pos_end");
        tick();
        chk("s4_base", 32'(fb_base_addr), 32'(22'h2AAAAA));
        chk("s4_ack", 32'(swap_ack), 32'd1);
        $display("[TB] re-request after reset: fb_base_addr=%06h", fb_base_addr);
        wait_ack_clear("s4");

        back_addr = 22'h111111;
        swap_req  = 1'b1;
        wait_pos(H - 1, V - 1, "s5_pos_end");
        tick();
        chk("s5_base", 32'(fb_base_addr), 32'(22'h111111));
        back_addr = 22'h222222;
        for (int f = 0; f < 2; f++) begin
            tick();
            wait_pos(0, 0, "s5_pos_fs");
            chk("s5_base_held", 32'(fb_base_addr), 32'(22'h111111));
            chk("s5_ack_held", 32'(swap_ack), 32'd1);
            $display("[TB] held request frame %0d: fb_base_addr=%06h swap_ack=%0d", f + 2, fb_base_addr, swap_ack);
        end
        wait_ack_clear("s5");
        tick();
        wait_pos(0, 0, "s5_pos_final");
        chk("s5_no_second", 32'(fb_base_addr), 32'(22'h111111));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
